// File: rtl/fir_tap_engine.sv
// fir_tap_engine: TAPS-tap direct-form FIR with a two-stage pipeline,
// product registers, then a saturating adder tree.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   clear              flush delay line and pipeline; coefficients kept
//   in_valid, x        input sample strobe and signed sample
//   coef_we/addr/data  coefficient write port, h[coef_addr] <= coef_data
//   out_valid          one-cycle pulse per accepted sample, two edges later
//   y, sat             saturated filter output and clip flag, held between pulses
module fir_tap_engine #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    parameter int OUT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic signed [DATA_W-1:0]  x,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_data,
    output logic                      out_valid,
    output logic signed [OUT_W-1:0]   y,
    output logic                      sat
);

    localparam int AW    = $clog2(TAPS);
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = PW + AW;

    localparam logic [AW:0] TAPS_L = (AW+1)'(TAPS);

    logic signed [DATA_W-1:0] r_tap  [TAPS];
    logic signed [COEF_W-1:0] r_h    [TAPS];
    logic signed [PW-1:0]     r_prod [TAPS];
    logic                     r_v1;
    logic                     r_v2;
    logic signed [OUT_W-1:0]  r_y;
    logic                     r_sat;

    logic signed [DATA_W-1:0] w_tap_new [TAPS];
    logic signed [ACC_W-1:0]  w_sum;
    logic [ACC_W-OUT_W:0]     w_hi;
    logic                     w_fits;
    logic signed [OUT_W-1:0]  w_y;
    logic                     w_sat;
    logic                     w_addr_ok;

    // Tap values as they will be after an accepting edge; the products
    // are formed from these so the new sample enters this cycle's sum.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            w_tap_new[k] = (k == 0) ? x : r_tap[(k == 0) ? 0 : k-1];
        end
    end

    // Full-precision adder tree, products sign-extended to ACC_W.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            w_sum = w_sum + ACC_W'(r_prod[k]);
        end
    end

    // The sum fits in OUT_W when every bit above the output sign bit
    // matches it; otherwise clip toward the sign of the sum.
    assign w_hi   = w_sum[ACC_W-1:OUT_W-1];
    assign w_fits = (&w_hi) | ~(|w_hi);

    always_comb begin
        w_y   = w_sum[OUT_W-1:0];
        w_sat = 1'b0;
        if (!w_fits) begin
            w_sat = 1'b1;
            if (w_sum[ACC_W-1]) begin
                w_y = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                w_y = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end

    assign w_addr_ok = ({1'b0, coef_addr} < TAPS_L);

    // Delay line and product stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_tap[k]  <= '0;
                r_prod[k] <= '0;
            end
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else if (clear) begin
            for (int k = 0; k < TAPS; k++) begin
                r_tap[k] <= '0;
            end
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            if (in_valid) begin
                for (int k = 0; k < TAPS; k++) begin
                    r_tap[k]  <= w_tap_new[k];
                    r_prod[k] <= PW'(r_h[k]) * PW'(w_tap_new[k]);
                end
            end
        end
    end

    // Coefficients: nonblocking update means a sample accepted on the
    // write edge still multiplies by the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_h[k] <= '0;
            end
        end else if (coef_we && w_addr_ok) begin
            r_h[coef_addr] <= coef_data;
        end
    end

    // Output stage; clear drops the in-flight product without touching y.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_y   <= '0;
            r_sat <= 1'b0;
        end else if (!clear && r_v1) begin
            r_y   <= w_y;
            r_sat <= w_sat;
        end
    end

    assign out_valid = r_v2;
    assign y         = r_y;
    assign sat       = r_sat;

endmodule

// File: tb/tb_fir_tap_engine.sv
// tb_fir_tap_engine: scoreboard bench for fir_tap_engine (default params).
// Driver models each edge arithmetically; a negedge monitor checks outputs.
module tb_fir_tap_engine;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic              in_valid;
    logic signed [7:0] x;
    logic              coef_we;
    logic [1:0]        coef_addr;
    logic signed [7:0] coef_data;
    logic              out_valid;
    logic signed [15:0] y;
    logic              sat;

    fir_tap_engine dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .x         (x),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .y         (y),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Expected {sat, y} for samples that will reach the output.
    logic [16:0] exp_q[$];

    // Reference state: coefficients, sample history, one sample in flight.
    int          m_h[4];
    int          m_t[4];
    logic        pend_v;
    logic [16:0] pend_e;

    function automatic logic [16:0] ref_out(input int s);
        if (s > 32767)  return {1'b1, 16'h7fff};
        if (s < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(s)};
    endfunction

    // Apply one edge worth of inputs and advance the reference model.
    task automatic step(input logic rst, input logic clr, input logic iv,
                        input logic signed [7:0] xv, input logic we,
                        input logic [1:0] a, input logic signed [7:0] d);
        int s;
        reset = rst; clear = clr; in_valid = iv; x = xv;
        coef_we = we; coef_addr = a; coef_data = d;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin m_h[k] = 0; m_t[k] = 0; end
            pend_v = 1'b0;
        end else begin
            if (pend_v && !clr) exp_q.push_back(pend_e);
            pend_v = 1'b0;
            if (clr) begin
                for (int k = 0; k < 4; k++) m_t[k] = 0;
            end else if (iv) begin
                for (int k = 3; k > 0; k--) m_t[k] = m_t[k-1];
                m_t[0] = int'(xv);
                s = 0;
                for (int k = 0; k < 4; k++) s += m_h[k] * m_t[k];
                pend_e = ref_out(s);
                pend_v = 1'b1;
            end
            if (we) m_h[a] = int'(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'sd0, 0, 2'd0, 8'sd0);
    endtask

    task automatic samp(input logic signed [7:0] xv);
        step(0, 0, 1, xv, 0, 2'd0, 8'sd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic signed [7:0] d);
        step(0, 0, 0, 8'sd0, 1, a, d);
    endtask

    task automatic set_h(input logic signed [7:0] h0, h1, h2, h3);
        wr(2'd0, h0); wr(2'd1, h1); wr(2'd2, h2); wr(2'd3, h3);
    endtask

    // Monitor: rst_q marks that the edge just past was a reset edge.
    logic        rst_q;
    logic [16:0] last_e;

    always @(posedge clk) rst_q <= reset;

    always @(negedge clk) begin
        logic [16:0] e;
        if (rst_q === 1'b1) begin
            vectors++;
            if (out_valid !== 1'b0 || {sat, y} !== 17'd0) begin
                errors++;
                $display("FAIL reset: ov=%b sat=%b y=%0d, want 0/0/0",
                         out_valid, sat, y);
            end
            last_e = 17'd0;
        end else if (out_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious: out_valid with sat=%b y=%0d, none expected",
                         sat, y);
            end else begin
                e = exp_q.pop_front();
                if ({sat, y} !== e) begin
                    errors++;
                    $display("FAIL output: sat=%b y=%0d, want sat=%b y=%0d",
                             sat, y, e[16], $signed(e[15:0]));
                end
                last_e = e;
            end
        end else if (rst_q === 1'b0) begin
            vectors++;
            if (out_valid !== 1'b0 || {sat, y} !== last_e) begin
                errors++;
                $display("FAIL hold: ov=%b sat=%b y=%0d, want 0/%b/%0d",
                         out_valid, sat, y, last_e[16], $signed(last_e[15:0]));
            end
        end
    end

    initial begin
        pend_v = 1'b0;
        for (int k = 0; k < 4; k++) begin m_h[k] = 0; m_t[k] = 0; end
        last_e = 17'd0;

        step(1, 0, 0, 8'sd0, 0, 2'd0, 8'sd0);
        step(1, 1, 1, 8'sd5, 1, 2'd1, 8'sd9);

        // Zero coefficients after reset give zero for any input.
        samp(8'sd127); samp(-8'sd128); samp(8'sd33); idle(3);

        // Impulse, then a gapped pair.
        set_h(8'sd2, 8'sd4, 8'sd4, 8'sd2);
        samp(8'sd1); samp(8'sd0); samp(8'sd0); samp(8'sd0);
        samp(8'sd0); idle(3);
        samp(8'sd1); idle(3); samp(8'sd0); idle(3);

        // Positive and negative saturation.
        set_h(8'sd127, 8'sd127, 8'sd127, 8'sd127);
        for (int i = 0; i < 4; i++) samp(8'sd127);
        for (int i = 0; i < 4; i++) samp(-8'sd128);
        idle(2);

        // Coefficient write on the same edge as a sample.
        set_h(8'sd2, 8'sd4, 8'sd4, 8'sd2);
        for (int i = 0; i < 4; i++) samp(8'sd0);
        step(0, 0, 1, 8'sd1, 1, 2'd0, 8'sd5);
        samp(8'sd1); idle(3);

        // Clear one cycle after a sample; in_valid on the clear edge ignored.
        samp(8'sd1);
        step(0, 1, 1, 8'sd7, 0, 2'd0, 8'sd0);
        idle(2); samp(8'sd1); idle(3);

        // Reset mid-flight wipes coefficients too.
        samp(8'sd1);
        step(1, 0, 1, 8'sd7, 0, 2'd0, 8'sd0);
        idle(2); samp(8'sd1); idle(3);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 150) == 0, ($urandom % 40) == 0,
                 ($urandom % 4) != 0, 8'($urandom), ($urandom % 6) == 0,
                 2'($urandom), 8'($urandom));
        end
        idle(4);

        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outputs still pending, want 0",
                     exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fir_tap_engine.md
FIR_TAP_ENGINE -- requirements
Module: fir_tap_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning signed input sample width.
REQ-002 The block SHALL have parameter COEF_W, default 8, meaning signed coefficient width.
REQ-003 The block SHALL have parameter TAPS, default 4, legal range 2..16, meaning filter length.
REQ-004 The block SHALL have parameter OUT_W, default 16, meaning signed output width, OUT_W <= ACC_W.
REQ-005 The block SHALL use derived ACC_W = DATA_W+COEF_W+clog2(TAPS), the full-precision accumulator width.
REQ-006 The port list SHALL be, in order:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- clear  in  1  flush delay line and pipeline; coefficients kept
- in_valid  in  1  x carries a sample this cycle
- x  in  DATA_W  signed input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(TAPS)  coefficient index k
- coef_data  in  COEF_W  signed coefficient value
- out_valid  out  1  y and sat are valid this cycle, one-cycle pulse per sample
- y  out  OUT_W  signed filtered output
- sat  out  1  y was clipped for this sample

Function
REQ-007 The block SHALL compute y[n] = sum over k=0..TAPS-1 of h[k]*x[n-k] in ACC_W-bit signed arithmetic with no intermediate overflow, where x[n] is the current accepted sample.
REQ-008 The delay line SHALL shift only on edges where in_valid=1: tap0 <= x, tap k <= tap k-1; when in_valid=0 it SHALL hold.
REQ-009 Stage 1, on the accepting edge E, SHALL register the TAPS products h[k]*tap-k, using the new tap values including x.
REQ-010 Stage 2, on edge E+1, SHALL register the adder-tree sum, saturated to OUT_W, into y.
REQ-011 Latency SHALL be 2 edges: out_valid=1 for exactly one cycle after edge E+1, and every accepted sample SHALL produce exactly one out_valid pulse.
REQ-012 Back-to-back in_valid SHALL give back-to-back out_valid with no bubbles, and in_valid gaps SHALL appear as identical gaps on out_valid.
REQ-013 When out_valid=0, y and sat SHALL hold their last values.
REQ-014 Saturation: if the sum exceeds 2^(OUT_W-1)-1, y SHALL equal that maximum and sat=1; if it is below -2^(OUT_W-1), y SHALL equal that minimum and sat=1; otherwise y SHALL be the sum truncated to OUT_W (no rounding) and sat=0.
REQ-015 A coefficient write on edge E SHALL set h[coef_addr] <= coef_data, effective for products registered on edge E+1 onward.
REQ-016 A sample accepted on the same edge as a coefficient write SHALL use the old coefficient.
REQ-017 A coef_addr >= TAPS SHALL ignore the write.
REQ-018 clear=1 SHALL zero all taps and both pipeline valid bits on that edge, and SHALL ignore in_valid on that edge.
REQ-019 A sample in flight when clear is asserted SHALL be dropped with no out_valid.
REQ-020 clear SHALL NOT change the coefficients, y or sat.
REQ-021 If reset and clear are both asserted, reset SHALL take priority.

Reset
REQ-022 On reset, all taps, all coefficients h[k], pipeline registers and valid bits, y and sat SHALL be 0.
REQ-023 On reset, out_valid SHALL be 0 on the following cycle.
REQ-024 Reset asserted mid-stream SHALL discard in-flight samples, and no out_valid SHALL follow from them.
REQ-025 After reset with no coefficient writes, any input SHALL yield y=0 and sat=0.

Verification
REQ-026 Impulse test: defaults, h={2,4,4,2}, x=1 then 0,0,0 with in_valid continuous -> y=2,4,4,2 on consecutive out_valid cycles, 2 edges after each sample, then y=0.
REQ-027 Gapped input test: same h, x=1, idle 3 cycles, x=0 -> exactly two out_valid pulses, y=2 then y=4, each 2 edges after its sample, and y holds 2 while idle.
REQ-028 Saturation test: OUT_W=8, h={127,127,127,127}, step x=127 -> y=127 with sat=1 from the first sample.
REQ-029 Negative saturation test: OUT_W=8, h={127,127,127,127}, x=-128 -> y=-128 with sat=1.
REQ-030 Coefficient-write collision test: write h[0]=5 on the same edge as sample x=1 (old h[0]=2) -> that sample gives y=2; the next sample x=1 gives y=5+4=9.
REQ-031 Clear/reset mid-flight test: assert clear one cycle after a sample with in_valid -> no out_valid for it; the next x=1 gives y=h[0] with the coefficients unchanged. Repeating with reset instead -> y=0.
